// File: rtl/matmul_seq_ctrl.sv
// Sequencer for the 4x4 matrix-multiply datapath: loads A then B over a byte
// stream, waits the datapath latency, snapshots C and drains it as words.
//
// state   | meaning
// IDLE    | waiting for start_i
// LOAD_A  | accepting the 16 A bytes, row-major
// LOAD_B  | accepting the 16 B bytes, row-major
// COMPUTE | latency timer running; snapshot of mat_c_i at terminal count
// DRAIN   | presenting the 16 result words to the sink
module matmul_seq_ctrl #(
   parameter int MUL_LATENCY = 1,
   parameter int DAT_W       = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   start_i,
   input  logic                   clear_i,
   output logic                   busy_o,
   output logic                   done_o,
   input  logic                   in_valid_i,
   input  logic [DAT_W-1:0]       in_data_i,
   output logic                   in_ready_o,
   output logic [16*DAT_W-1:0]    mat_a_o,
   output logic [16*DAT_W-1:0]    mat_b_o,
   input  logic [16*2*DAT_W-1:0]  mat_c_i,
   output logic                   out_valid_o,
   output logic [2*DAT_W-1:0]     out_data_o,
   output logic                   out_last_o,
   input  logic                   out_ready_i
);

   localparam int RES_W = 2 * DAT_W;
   localparam int CNT_W = 3;

   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      COMPUTE,
      DRAIN
   } state_t;

   state_t               state;
   state_t               state_nxt;
   logic [3:0]           idx;
   logic [CNT_W-1:0]     cnt;
   logic [16*RES_W-1:0]  res_buf;
   logic                 in_hs;
   logic                 out_hs;
   logic                 last_idx;
   logic                 cnt_tc;

   assign busy_o      = (state != IDLE);
   assign in_ready_o  = (state == LOAD_A) || (state == LOAD_B);
   assign out_valid_o = (state == DRAIN);
   assign last_idx    = (idx == 4'd15);
   assign out_last_o  = out_valid_o && last_idx;
   assign out_data_o  = res_buf[32'(idx)*RES_W +: RES_W];
   assign in_hs       = in_valid_i && in_ready_o;
   assign out_hs      = out_valid_o && out_ready_i;
   assign cnt_tc      = (cnt == '0);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_i)            state_nxt = LOAD_A;
         LOAD_A:  if (in_hs && last_idx)  state_nxt = LOAD_B;
         LOAD_B:  if (in_hs && last_idx)  state_nxt = COMPUTE;
         COMPUTE: if (cnt_tc)             state_nxt = DRAIN;
         DRAIN:   if (out_hs && last_idx) state_nxt = IDLE;
         default:                         state_nxt = IDLE;
      endcase
      if (clear_i) begin
         state_nxt = IDLE;
      end
   end

   // Latency timer is a down-counter loaded on the last B byte; COMPUTE
   // spans MUL_LATENCY+1 cycles with the capture on terminal count.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         idx     <= '0;
         cnt     <= '0;
         done_o  <= 1'b0;
         mat_a_o <= '0;
         mat_b_o <= '0;
         res_buf <= '0;
      end else if (clear_i) begin
         idx    <= '0;
         cnt    <= '0;
         done_o <= 1'b0;
      end else begin
         done_o <= out_hs && last_idx;
         case (state)
            IDLE: begin
               idx <= '0;
            end
            LOAD_A: begin
               if (in_hs) begin
                  mat_a_o[32'(idx)*DAT_W +: DAT_W] <= in_data_i;
                  idx <= idx + 4'd1;
               end
            end
            LOAD_B: begin
               if (in_hs) begin
                  mat_b_o[32'(idx)*DAT_W +: DAT_W] <= in_data_i;
                  idx <= idx + 4'd1;
                  if (last_idx) begin
                     cnt <= CNT_W'(MUL_LATENCY);
                  end
               end
            end
            COMPUTE: begin
               if (cnt_tc) begin
                  res_buf <= mat_c_i;
                  idx     <= '0;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            DRAIN: begin
               if (out_hs) begin
                  idx <= idx + 4'd1;
               end
            end
            default: begin
               idx <= '0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_matmul_seq_ctrl.sv
// Scoreboard bench for matmul_seq_ctrl (MUL_LATENCY=3) with a behavioural
// three-stage datapath model feeding mat_c_i.
module tb_matmul_seq_ctrl;

   localparam int LAT = 3;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start_i = 1'b0;
   logic          clear_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic [7:0]    in_data_i = '0;
   logic          out_ready_i = 1'b0;
   logic          busy_o, done_o, in_ready_o, out_valid_o, out_last_o;
   logic [127:0]  mat_a_o, mat_b_o;
   logic [255:0]  mat_c_i;
   logic [15:0]   out_data_o;

   matmul_seq_ctrl #(.MUL_LATENCY(LAT), .DAT_W(8)) dut (
      .clk(clk), .rst_n(rst_n), .start_i(start_i), .clear_i(clear_i),
      .busy_o(busy_o), .done_o(done_o),
      .in_valid_i(in_valid_i), .in_data_i(in_data_i), .in_ready_o(in_ready_o),
      .mat_a_o(mat_a_o), .mat_b_o(mat_b_o), .mat_c_i(mat_c_i),
      .out_valid_o(out_valid_o), .out_data_o(out_data_o),
      .out_last_o(out_last_o), .out_ready_i(out_ready_i)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int base = 0;
   bit lat_mode = 1'b0;
   bit ready_mode = 1'b0;
   logic [7:0]  va [16];
   logic [7:0]  vb [16];
   logic [16:0] sb [$];
   logic [255:0] p1 = '0, p2 = '0, p3 = '0;

   function automatic logic [255:0] matmul(input logic [127:0] a, input logic [127:0] b);
      logic [255:0] c;
      logic [15:0]  s;
      c = '0;
      for (int r = 0; r < 4; r++)
         for (int col = 0; col < 4; col++) begin
            s = '0;
            for (int k = 0; k < 4; k++)
               s = s + 16'(a[(4*r+k)*8 +: 8]) * 16'(b[(4*k+col)*8 +: 8]);
            c[(4*r+col)*16 +: 16] = s;
         end
      return c;
   endfunction

   always @(posedge clk) begin
      cyc <= cyc + 1;
      p1  <= matmul(mat_a_o, mat_b_o);
      p2  <= p1;
      p3  <= p2;
   end

   // In lat_mode every element carries the number of edges since the last B accept.
   always_comb begin
      mat_c_i = p3;
      if (lat_mode)
         for (int i = 0; i < 16; i++)
            mat_c_i[i*16 +: 16] = {4'(cyc - base), 4'h0, 8'(i)};
   end

   always @(posedge clk) begin
      #1;
      out_ready_i = ready_mode ? ((cyc % 3) == 0) : 1'b1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Monitor: pops the scoreboard on every output handshake.
   logic        held_v = 1'b0;
   logic [15:0] held_d = '0;
   bit          exp_done = 1'b0;
   logic [16:0] e;
   always @(negedge clk) begin
      if (rst_n) begin
         chk("done_o", 32'(done_o), 32'(exp_done));
         exp_done = 1'b0;
         if (held_v) begin
            chk("hold_valid", 32'(out_valid_o), 32'd1);
            chk("hold_data", 32'(out_data_o), 32'(held_d));
         end
         held_v = 1'b0;
         if (out_valid_o) begin
            if (out_ready_i) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_word: got %0h expected none", out_data_o);
               end else begin
                  e = sb.pop_front();
                  chk("out_data", 32'(out_data_o), 32'(e[15:0]));
                  chk("out_last", 32'(out_last_o), 32'(e[16]));
               end
               exp_done = out_last_o;
            end else begin
               held_v = 1'b1;
               held_d = out_data_o;
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] d, input bit gap);
      bit acc;
      int n;
      if (gap) begin
         in_valid_i = 1'b0;
         tick();
      end
      in_valid_i = 1'b1;
      in_data_i  = d;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 50) begin
         @(negedge clk);
         acc = in_ready_o;
         tick();
         n++;
      end
      if (!acc) begin
         checks++;
         errors++;
         $display("FAIL in_ready_timeout: got 0 expected 1");
      end
   endtask

   // Sends A then B; optionally pulses start_i before B byte start_at (0 = never).
   task automatic load(input bit gaps, input int start_at);
      for (int i = 0; i < 32; i++) begin
         if (start_at != 0 && i == 16 + start_at) begin
            in_valid_i = 1'b0;
            start_i = 1'b1;
            tick();
            start_i = 1'b0;
            chk("start_in_load_b_ready", 32'(in_ready_o), 32'd1);
         end
         send_byte(i < 16 ? va[i] : vb[i-16], gaps);
      end
      in_valid_i = 1'b0;
      base = cyc;
   endtask

   task automatic wait_done(input bit b2b);
      bit found;
      found = 1'b0;
      for (int n = 0; n < 1000 && !found; n++) begin
         @(negedge clk);
         if (done_o) begin
            found = 1'b1;
            if (b2b) start_i = 1'b1;
         end
      end
      if (!found) begin
         checks++;
         errors++;
         $display("FAIL done_timeout: got 0 expected 1");
      end
      tick();
      start_i = 1'b0;
      if (b2b) begin
         chk("b2b_busy", 32'(busy_o), 32'd1);
         chk("b2b_in_ready", 32'(in_ready_o), 32'd1);
      end else begin
         chk("idle_busy", 32'(busy_o), 32'd0);
      end
   endtask

   task automatic set_identity(input logic [7:0] scale);
      for (int i = 0; i < 16; i++)
         va[i] = (i % 5 == 0) ? scale : 8'd0;
   endtask

   initial begin
      logic [127:0] exp_a;
      bit seen;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_busy", 32'(busy_o), 32'd0);
      chk("rst_done", 32'(done_o), 32'd0);
      chk("rst_in_ready", 32'(in_ready_o), 32'd0);
      chk("rst_out_valid", 32'(out_valid_o), 32'd0);
      chk("rst_out_last", 32'(out_last_o), 32'd0);
      chk("rst_mat_a", 32'(mat_a_o != '0), 32'd0);
      chk("rst_mat_b", 32'(mat_b_o != '0), 32'd0);
      rst_n = 1'b1;
      tick();

      // identity x (1..16), start pulse ignored in LOAD_B, back-to-back start
      set_identity(8'd1);
      for (int i = 0; i < 16; i++) begin
         vb[i] = 8'(i + 1);
         sb.push_back({(i == 15), 16'(i + 1)});
      end
      do_start();
      chk("load_a_ready", 32'(in_ready_o), 32'd1);
      load(1'b0, 8);
      wait_done(1'b1);

      // overflow: 4*255*255 = 260100 -> 63492
      for (int i = 0; i < 16; i++) begin
         va[i] = 8'd255;
         vb[i] = 8'd255;
         sb.push_back({(i == 15), 16'd63492});
      end
      load(1'b0, 0);
      wait_done(1'b0);

      // input gaps, sink ready every 3rd cycle, start ignored in DRAIN
      ready_mode = 1'b1;
      set_identity(8'd2);
      for (int i = 0; i < 16; i++) begin
         vb[i] = 8'(i + 1);
         sb.push_back({(i == 15), 16'(2 * (i + 1))});
      end
      do_start();
      load(1'b1, 0);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         tick();
         seen = out_valid_o;
      end
      chk("drain_reached", 32'(seen), 32'd1);
      start_i = 1'b1;
      tick();
      start_i = 1'b0;
      wait_done(1'b0);
      ready_mode = 1'b0;

      // COMPUTE length and capture edge: marker 3 is sampled on the 4th edge
      lat_mode = 1'b1;
      set_identity(8'd1);
      for (int i = 0; i < 16; i++) begin
         vb[i] = 8'd1;
         sb.push_back({(i == 15), 16'h3000 + 16'(i)});
      end
      do_start();
      load(1'b0, 0);
      for (int k = 1; k <= LAT + 1; k++) begin
         chk("compute_busy", 32'(busy_o), 32'd1);
         chk("compute_in_ready", 32'(in_ready_o), 32'd0);
         tick();
         chk("compute_len", 32'(out_valid_o), 32'(k == LAT + 1));
      end
      wait_done(1'b0);
      lat_mode = 1'b0;

      // clear after 7 B bytes, operands retained, then full reload
      for (int i = 0; i < 16; i++) begin
         va[i] = 8'h10 + 8'(i);
         vb[i] = 8'h20 + 8'(i);
         exp_a[i*8 +: 8] = 8'h10 + 8'(i);
      end
      do_start();
      for (int i = 0; i < 23; i++) send_byte(i < 16 ? va[i] : vb[i-16], 1'b0);
      in_valid_i = 1'b0;
      clear_i = 1'b1;
      tick();
      clear_i = 1'b0;
      chk("clear_busy", 32'(busy_o), 32'd0);
      chk("clear_in_ready", 32'(in_ready_o), 32'd0);
      chk("clear_out_valid", 32'(out_valid_o), 32'd0);
      chk("clear_keep_a", 32'(mat_a_o == exp_a), 32'd1);
      for (int i = 0; i < 7; i++)
         chk("clear_keep_b", 32'(mat_b_o[i*8 +: 8]), 32'(8'h20 + 8'(i)));
      repeat (3) tick();
      set_identity(8'd1);
      for (int i = 0; i < 16; i++) begin
         vb[i] = 8'(16 - i);
         sb.push_back({(i == 15), 16'(16 - i)});
      end
      do_start();
      load(1'b0, 0);
      wait_done(1'b0);

      // clear wins over start in IDLE
      clear_i = 1'b1;
      start_i = 1'b1;
      tick();
      clear_i = 1'b0;
      start_i = 1'b0;
      chk("clear_start_busy", 32'(busy_o), 32'd0);
      tick();
      chk("clear_start_in_ready", 32'(in_ready_o), 32'd0);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
